// File: rtl/keycode_lock_fsm.sv
// Passcode checker for the 2-button key encoder: compares each completed keycode
// against PASSCODE, counts misses toward a timed lockout, and auto-relocks after unlocking.
module keycode_lock_fsm #(
  parameter logic [3:0] PASSCODE       = 4'b1010,
  parameter int         MAX_TRIES      = 3,
  parameter int         UNLOCK_CYCLES  = 8,
  parameter int         LOCKOUT_CYCLES = 16,
  parameter int         CNT_W          = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] keycode,
  input  logic       move_on,
  output logic       unlocked,
  output logic       locked_out,
  output logic       match_pulse,
  output logic       fail_pulse,
  output logic [3:0] tries_left,
  output logic [1:0] state_dbg
);

  // move_on is a one-cycle qualifier with no back-pressure: keycode is consumed
  // only on cycles where move_on=1, and every such cycle is acted on (or dropped in LOCKOUT).
  typedef enum logic [1:0] {
    ST_LOCKED  = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] UNLOCK_LOAD  = CNT_W'(UNLOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCKOUT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMER_ONE    = CNT_W'(1);
  localparam logic [3:0]       MAX_T        = 4'(MAX_TRIES);

  state_e           state_q, state_d;
  logic [3:0]       fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             unlocked_q, unlocked_d;
  logic             locked_out_q, locked_out_d;
  logic             match_pulse_q, match_pulse_d;
  logic             fail_pulse_q, fail_pulse_d;
  logic [3:0]       tries_left_q, tries_left_d;
  logic             last_try;

  // True when the miss being counted now is the one that reaches MAX_TRIES.
  assign last_try = ({1'b0, fail_cnt_q} + 5'd1) >= {1'b0, MAX_T};

  always_comb begin
    state_d       = state_q;
    fail_cnt_d    = fail_cnt_q;
    timer_d       = '0;
    match_pulse_d = 1'b0;
    fail_pulse_d  = 1'b0;
    case (state_q)
      ST_LOCKED: begin
        if (move_on) begin
          if (keycode == PASSCODE) begin
            state_d       = ST_OPEN;
            timer_d       = UNLOCK_LOAD;
            fail_cnt_d    = 4'd0;
            match_pulse_d = 1'b1;
          end else if (last_try) begin
            state_d      = ST_LOCKOUT;
            timer_d      = LOCKOUT_LOAD;
            fail_cnt_d   = 4'd0;
            fail_pulse_d = 1'b1;
          end else begin
            fail_cnt_d   = fail_cnt_q + 4'd1;
            fail_pulse_d = 1'b1;
          end
        end
      end
      ST_OPEN: begin
        if (move_on || timer_q == '0) begin
          state_d = ST_LOCKED;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d    = ST_LOCKED;
          fail_cnt_d = 4'd0;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      default: begin
        state_d    = ST_LOCKED;
        fail_cnt_d = 4'd0;
      end
    endcase

    // Outputs are decoded from the next state so they change on the same edge.
    unlocked_d   = (state_d == ST_OPEN);
    locked_out_d = (state_d == ST_LOCKOUT);
    case (state_d)
      ST_LOCKED:  tries_left_d = MAX_T - fail_cnt_d;
      ST_OPEN:    tries_left_d = MAX_T;
      default:    tries_left_d = 4'd0;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= ST_LOCKED;
      fail_cnt_q    <= 4'd0;
      timer_q       <= '0;
      unlocked_q    <= 1'b0;
      locked_out_q  <= 1'b0;
      match_pulse_q <= 1'b0;
      fail_pulse_q  <= 1'b0;
      tries_left_q  <= MAX_T;
    end else begin
      state_q       <= state_d;
      fail_cnt_q    <= fail_cnt_d;
      timer_q       <= timer_d;
      unlocked_q    <= unlocked_d;
      locked_out_q  <= locked_out_d;
      match_pulse_q <= match_pulse_d;
      fail_pulse_q  <= fail_pulse_d;
      tries_left_q  <= tries_left_d;
    end
  end

  assign unlocked    = unlocked_q;
  assign locked_out  = locked_out_q;
  assign match_pulse = match_pulse_q;
  assign fail_pulse  = fail_pulse_q;
  assign tries_left  = tries_left_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_keycode_lock_fsm.sv
// Directed bench for keycode_lock_fsm with default parameters: unlock, lockout,
// ignored input during lockout, miss-then-hit, manual relock and mid-lockout reset.
module tb_keycode_lock_fsm;

  logic       clk;
  logic       nrst;
  logic [3:0] keycode;
  logic       move_on;
  logic       unlocked;
  logic       locked_out;
  logic       match_pulse;
  logic       fail_pulse;
  logic [3:0] tries_left;
  logic [1:0] state_dbg;

  int n_checks;
  int n_errors;
  int n;

  keycode_lock_fsm dut (
    .clk         (clk),
    .nrst        (nrst),
    .keycode     (keycode),
    .move_on     (move_on),
    .unlocked    (unlocked),
    .locked_out  (locked_out),
    .match_pulse (match_pulse),
    .fail_pulse  (fail_pulse),
    .tries_left  (tries_left),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge, outputs are sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code);
    keycode = code;
    move_on = 1'b1;
    tick();
    move_on = 1'b0;
    keycode = 4'h0;
  endtask

  // Counts the samples (from the current one) where unlocked (sel=0) or locked_out (sel=1) is high.
  task automatic dwell(input bit sel, output int cnt);
    cnt = 1;
    for (int g = 0; g < 100; g++) begin
      tick();
      if (sel ? locked_out : unlocked) begin
        cnt++;
        if (!sel) check("open_tries", tries_left, 3);
        else      check("lockout_tries", tries_left, 0);
      end else begin
        break;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    nrst     = 1'b0;
    move_on  = 1'b0;
    keycode  = 4'h0;
    tick();
    tick();
    check("rst_unlocked", unlocked, 0);
    check("rst_locked_out", locked_out, 0);
    check("rst_match", match_pulse, 0);
    check("rst_fail", fail_pulse, 0);
    check("rst_tries", tries_left, 3);
    nrst = 1'b1;
    tick();

    // 1: correct code unlocks for exactly 8 cycles
    press(4'b1010);
    check("t1_match", match_pulse, 1);
    check("t1_unlocked", unlocked, 1);
    check("t1_tries", tries_left, 3);
    dwell(1'b0, n);
    check("t1_open_len", n, 8);
    check("t1_unlocked_after", unlocked, 0);
    check("t1_match_after", match_pulse, 0);
    check("t1_tries_after", tries_left, 3);

    // 2: three misses -> 16-cycle lockout -> LOCKED with 3 tries
    press(4'b0000);
    check("t2_fail1", fail_pulse, 1);
    check("t2_tries1", tries_left, 2);
    tick();
    check("t2_fail1_off", fail_pulse, 0);
    press(4'b0000);
    check("t2_tries2", tries_left, 1);
    press(4'b0000);
    check("t2_fail3", fail_pulse, 1);
    check("t2_match3", match_pulse, 0);
    check("t2_lockout", locked_out, 1);
    check("t2_tries3", tries_left, 0);
    dwell(1'b1, n);
    check("t2_lockout_len", n, 16);
    check("t2_locked_out_after", locked_out, 0);
    check("t2_tries_after", tries_left, 3);

    // 3: correct code during lockout, including on its final cycle, is ignored
    press(4'b0000);
    press(4'b0000);
    press(4'b0000);
    check("t3_lockout", locked_out, 1);
    for (int i = 2; i <= 17; i++) begin
      if (i == 4 || i == 17) press(4'b1010);
      else tick();
      check("t3_locked_out", locked_out, (i <= 16) ? 1 : 0);
      check("t3_no_match", match_pulse, 0);
      check("t3_no_fail", fail_pulse, 0);
      check("t3_unlocked", unlocked, 0);
    end
    check("t3_tries_after", tries_left, 3);

    // 4: two misses then a hit
    press(4'b0001);
    check("t4_tries1", tries_left, 2);
    press(4'b1111);
    check("t4_tries2", tries_left, 1);
    press(4'b1010);
    check("t4_match", match_pulse, 1);
    check("t4_fail", fail_pulse, 0);
    check("t4_unlocked", unlocked, 1);
    check("t4_tries", tries_left, 3);

    // 5: manual relock on the 3rd OPEN cycle
    tick();
    tick();
    check("t5_open3", unlocked, 1);
    press(4'b0110);
    check("t5_relocked", unlocked, 0);
    check("t5_no_fail", fail_pulse, 0);
    check("t5_no_match", match_pulse, 0);
    check("t5_tries", tries_left, 3);
    press(4'b0110);
    check("t5_miss_counts", tries_left, 2);
    check("t5_miss_fail", fail_pulse, 1);
    press(4'b1010);
    check("t5_reunlock", unlocked, 1);
    dwell(1'b0, n);
    check("t5_open_len", n, 8);

    // 6: async reset mid-lockout, then a normal unlock
    press(4'b0000);
    press(4'b0000);
    press(4'b0000);
    for (int i = 0; i < 4; i++) tick();
    check("t6_lockout_c5", locked_out, 1);
    #2;
    nrst = 1'b0;
    #1;
    check("t6_rst_locked_out", locked_out, 0);
    check("t6_rst_tries", tries_left, 3);
    check("t6_rst_fail", fail_pulse, 0);
    tick();
    nrst = 1'b1;
    tick();
    check("t6_idle_locked_out", locked_out, 0);
    press(4'b1010);
    check("t6_match", match_pulse, 1);
    check("t6_unlocked", unlocked, 1);
    dwell(1'b0, n);
    check("t6_open_len", n, 8);
    check("t6_tries_after", tries_left, 3);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
